// File: rtl/fx2_adc_stream_writer_pkg.sv
// Shared types and constants for the FX2LP ADC stream writer.
package fx2_stream_pkg;

    localparam int DROP_CNT_W = 16;

    typedef enum logic {
        IDLE,
        SEND
    } serState_e;

    function automatic int frameBytes(input int numCh, input int sampleWidth);
        return numCh * sampleWidth / 8;
    endfunction

endpackage

// File: rtl/fx2_adc_stream_writer_fifo.sv
// Frame FIFO with first-word fall-through read data; a pop frees a slot for a push on the same edge.
module frame_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W:0]   count_q;
    logic             doPush;
    logic             doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign rdata_o = mem_q[rdPtr_q];
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full_o || doPop);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
            count_q <= count_q + {{PTR_W{1'b0}}, doPush} - {{PTR_W{1'b0}}, doPop};
        end
    end

    // Storage is not reset; occupancy is governed solely by the pointers.
    always_ff @(posedge clk_i) begin
        if (doPush) mem_q[wrPtr_q] <= wdata_i;
    end

endmodule

// File: rtl/fx2_adc_stream_writer.sv
// ADC-to-FX2LP slave-FIFO writer: decimated frame capture, frame buffering, byte
// serialisation throttled by FLAGN, drop accounting and short-packet flush.
module fx2_adc_stream_writer
    import fx2_stream_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 8,
    parameter int NUM_CH       = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter int DIV_WIDTH    = 26,
    parameter int PKT_BYTES    = 512
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           enable_i,
    input  logic [DIV_WIDTH-1:0]           divisor_i,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0] adc_data_i,
    input  logic                           full_n_i,
    input  logic                           ovf_clr_i,
    output logic [7:0]                     fd_o,
    output logic                           slwr_n_o,
    output logic                           pktend_n_o,
    output logic                           overflow_o,
    output logic [DROP_CNT_W-1:0]          drop_cnt_o
);

    localparam int FRAME_W = NUM_CH * SAMPLE_WIDTH;
    localparam int FB      = frameBytes(NUM_CH, SAMPLE_WIDTH);
    localparam int IDX_W   = (FB > 1) ? $clog2(FB) : 1;
    localparam int PKT_W   = $clog2(PKT_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FB - 1);

    logic [FRAME_W-1:0]    adcData_q;
    logic [DIV_WIDTH-1:0]  decCnt_q, decCnt_d;
    serState_e             state_q, state_d;
    logic [FRAME_W-1:0]    shift_q, shift_d;
    logic [IDX_W-1:0]      byteIdx_q, byteIdx_d;
    logic [7:0]            fd_q, fd_d;
    logic                  slwrN_q, slwrN_d;
    logic                  pktendN_q, pktendN_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] dropCnt_q, dropCnt_d;
    logic [PKT_W-1:0]      byteCnt_q, byteCnt_d;

    logic [DIV_WIDTH-1:0]  effDiv;
    logic                  strobe;
    logic                  drop;
    logic                  flush;
    logic                  fifoPush;
    logic                  fifoPop;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic [FRAME_W-1:0]    fifoRdata;

    frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (fifoPush),
        .pop_i     (fifoPop),
        .wdata_i   (adcData_q),
        .rdata_o   (fifoRdata),
        .full_o    (fifoFull),
        .empty_o   (fifoEmpty)
    );

    assign effDiv = (divisor_i == '0) ? DIV_WIDTH'(1) : divisor_i;
    assign strobe = enable_i && (decCnt_q == '0);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            adcData_q  <= '0;
            decCnt_q   <= '0;
            state_q    <= IDLE;
            shift_q    <= '0;
            byteIdx_q  <= '0;
            fd_q       <= '0;
            slwrN_q    <= 1'b1;
            pktendN_q  <= 1'b1;
            overflow_q <= 1'b0;
            dropCnt_q  <= '0;
            byteCnt_q  <= '0;
        end else begin
            adcData_q  <= adc_data_i;
            decCnt_q   <= decCnt_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            byteIdx_q  <= byteIdx_d;
            fd_q       <= fd_d;
            slwrN_q    <= slwrN_d;
            pktendN_q  <= pktendN_d;
            overflow_q <= overflow_d;
            dropCnt_q  <= dropCnt_d;
            byteCnt_q  <= byteCnt_d;
        end
    end

    // The last byte of a frame pops the next one on the same edge, so frames stream back to back.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        byteIdx_d = byteIdx_q;
        fd_d      = fd_q;
        slwrN_d   = 1'b1;
        fifoPop   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    fifoPop   = 1'b1;
                    shift_d   = fifoRdata;
                    byteIdx_d = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (full_n_i) begin
                    fd_d      = shift_q[7:0];
                    slwrN_d   = 1'b0;
                    shift_d   = shift_q >> 8;
                    byteIdx_d = byteIdx_q + 1'b1;
                    if (byteIdx_q == LAST_IDX) begin
                        byteIdx_d = '0;
                        if (!fifoEmpty) begin
                            fifoPop = 1'b1;
                            shift_d = fifoRdata;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The >= wrap keeps the decimation counter from stranding when the divisor shrinks mid-run.
    always_comb begin
        decCnt_d   = decCnt_q;
        overflow_d = overflow_q;
        dropCnt_d  = dropCnt_q;
        byteCnt_d  = byteCnt_q;
        pktendN_d  = 1'b1;

        if (!enable_i) begin
            decCnt_d = '0;
        end else if (decCnt_q >= effDiv - 1'b1) begin
            decCnt_d = '0;
        end else begin
            decCnt_d = decCnt_q + 1'b1;
        end

        drop     = strobe && fifoFull && !fifoPop;
        fifoPush = strobe && !drop;

        if (ovf_clr_i) begin
            overflow_d = 1'b0;
            dropCnt_d  = {{(DROP_CNT_W-1){1'b0}}, drop};
        end else if (drop) begin
            overflow_d = 1'b1;
            if (dropCnt_q != '1) dropCnt_d = dropCnt_q + 1'b1;
        end

        // The byte counter already includes a write being registered this edge, so a full packet never flushes.
        flush = !enable_i && fifoEmpty && (state_q == IDLE) && (byteCnt_q != '0)
                && full_n_i && pktendN_q;
        if (flush) begin
            pktendN_d = 1'b0;
            byteCnt_d = '0;
        end else if (!slwrN_d) begin
            byteCnt_d = byteCnt_q + 1'b1;
        end
    end

    assign fd_o       = fd_q;
    assign slwr_n_o   = slwrN_q;
    assign pktend_n_o = pktendN_q;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = dropCnt_q;

endmodule
